// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_pkg
//  Purpose  : Shared FSM encoding, default operand width and counter sizing.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    localparam int c_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter must hold the value WIDTH, hence WIDTH+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : serial_subtractor_pkg
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_if
//  Purpose  : Request/result bundle between a requester and serial_subtractor.
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, Bin,
        input  D, Bout, busy, done
    );

    modport slave (
        input  start, A, B, Bin,
        output D, Bout, busy, done
    );

endinterface : serial_subtractor_if
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : full_subtractor
//  Purpose  : One-bit combinational subtract cell, x - y - bi.
//  Revision : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  wire  x,
    input  wire  y,
    input  wire  bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial A - B - Bin, LSB first, one bit per clock.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire                clk,
    input  wire                rst,
    serial_subtractor_if.slave bus
);

    localparam int                 c_CNT_W    = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_d;
    logic               r_bout;
    logic               r_done;

    logic               w_d;
    logic               w_bo;
    logic [WIDTH:0]     w_res_cat;

    full_subtractor u_cell (
        .x  (r_a[0]),
        .y  (r_b[0]),
        .bi (r_br),
        .d  (w_d),
        .bo (w_bo)
    );

    // New difference bit enters at the MSB so the LSB-first stream lands in order.
    assign w_res_cat = {w_d, r_res};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = SHIFT;
            SHIFT:   if (r_cnt == c_CNT_LAST) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.A;
                        r_b   <= bus.B;
                        r_br  <= bus.Bin;
                        r_res <= '0;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_cat[WIDTH:1];
                    r_br  <= w_bo;
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
                DONE: begin
                    r_d    <= r_res;
                    r_bout <= r_br;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.D    = r_d;
    assign bus.Bout = r_bout;
    assign bus.done = r_done;
    assign bus.busy = (r_state != IDLE);

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Self-checking bench for serial_subtractor (scoreboard + vectors).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int W = c_DEFAULT_WIDTH;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bout;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_done = 0;
    int   n_push = 0;
    exp_t sb[$];
    vec_t vecs[7];

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Called just after a negedge; start is seen by the next rising edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W-1:0] ed, input logic eb);
        exp_t e;
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        e.d    = ed;
        e.bout = eb;
        e.due  = cyc + W + 2;
        sb.push_back(e);
        n_push++;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_in_shift", int'(bus.busy), 1);
    endtask

    task automatic do_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] full;
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        do_op(a, b, bin, full[W-1:0], full[W]);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        check("idle_after_done", int'(bus.busy), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                check("done_without_start", int'(bus.done), 0);
            end else begin
                e = sb.pop_front();
                check("D", int'(bus.D), int'(e.d));
                check("Bout", int'(bus.Bout), int'(e.bout));
                check("done_latency", cyc, e.due);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd7,  4'd3,  1'b0, 4'd4,  1'b0};
        vecs[1] = '{4'd3,  4'd7,  1'b0, 4'd12, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
        vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
        vecs[4] = '{4'd8,  4'd1,  1'b1, 4'd6,  1'b0};
        vecs[5] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1};
        vecs[6] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_D", int'(bus.D), 0);
        check("rst_Bout", int'(bus.Bout), 0);

        // Reset must win over a simultaneous start.
        bus.start = 1'b1;
        bus.A     = 4'd5;
        @(negedge clk);
        check("rst_overrides_start", int'(bus.busy), 0);
        bus.start = 1'b0;
        rst       = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout);
            wait_drain();
        end

        // Back-to-back sweep, one start every W+2 cycles.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bin = 0; bin < 2; bin++) begin
                    do_model(4'(a), 4'(b), 1'(bin));
                    repeat (W + 1) @(negedge clk);
                end
        wait_drain();

        // Start re-asserted with new operands during SHIFT: must be ignored.
        do_op(4'd12, 4'd5, 1'b1, 4'd6, 1'b0);
        bus.start = 1'b1;
        bus.A     = 4'd0;
        bus.B     = 4'd15;
        bus.Bin   = 1'b1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        repeat (W + 3) @(negedge clk);

        // Reset during the third SHIFT cycle aborts without a done pulse.
        do_op(4'd10, 4'd3, 1'b0, 4'd7, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete(sb.size() - 1);
        n_push--;
        @(negedge clk);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_D", int'(bus.D), 0);
        check("abort_Bout", int'(bus.Bout), 0);
        rst = 1'b0;
        do_op(4'd9, 4'd4, 1'b0, 4'd5, 1'b0);
        wait_drain();
        repeat (W + 3) @(negedge clk);

        check("done_count", n_done, n_push);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
